uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 107 ++++++++++
 tb/tb_uart_tx_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART frame serialiser, one bit per CLK (CLK is the baud clock), registered TX_OUT/Busy.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2 state) to every frame.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
    , STOP2 = 3'd5
`endif
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg;
  logic                    par_typ_reg;
  logic                    tx_next;
  logic                    busy_next;
  logic                    accept;

  assign accept = (state_reg == IDLE) && Data_Valid;

  // Next state and bit counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE:   if (Data_Valid) state_next = START;
      START: begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
          cnt_next   = '0;
          state_next = par_en_reg ? PARITY : STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PARITY: state_next = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   state_next = STOP2;
      STOP2:  state_next = IDLE;
`else
      STOP:   state_next = IDLE;
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the state being entered so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[cnt_next];
      PARITY:  tx_next = (^data_reg) ^ par_typ_reg;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      TX_OUT    <= tx_next;
      Busy      <= busy_next;
      if (accept) begin
        data_reg    <= P_DATA;
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: stimulus pushes expected bits/lengths/gaps, a monitor pops on Busy.
// Honours UART_TX_TWO_STOP_EN to expect the second stop bit.
module tb_uart_tx_core;

`ifdef UART_TX_TWO_STOP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  logic bit_q[$];
  int   len_q[$];
  int   gap_q[$];

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence: start, data LSB first, optional parity, stop bit(s).
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic par, input int gap);
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    if (pen) bit_q.push_back(par);
    bit_q.push_back(1'b1);
    if (EXTRA == 1) bit_q.push_back(1'b1);
    len_q.push_back(2 + 8 + int'(pen) + EXTRA);
    gap_q.push_back(gap);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (!Busy) done = 1'b1;
    end
    if (!done) check("wait_idle_timeout", 32'(Busy), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic par);
    wait_idle();
    push_frame(d, pen, par, -1);
    $display("TX data=%02h par_en=%0b par_typ=%0b exp_par=%0b", d, pen, ptyp, par);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  // Monitor: Busy is the "output valid"; every busy cycle consumes one expected bit.
  initial begin
    bit prev_busy;
    int run_len;
    int idle_len;
    int g;
    prev_busy = 1'b0; run_len = 0; idle_len = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_busy = 1'b0; run_len = 0; idle_len = 0;
      end else begin
        if (Busy) begin
          if (!prev_busy) begin
            if (gap_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
            else begin
              g = gap_q.pop_front();
              if (g >= 0) check("idle_gap", 32'(idle_len), 32'(g));
            end
            run_len = 0;
          end
          run_len++;
          if (bit_q.size() == 0) check("unexpected_bit", 32'd1, 32'd0);
          else check("tx_bit", 32'(TX_OUT), 32'(bit_q.pop_front()));
        end else begin
          if (prev_busy) begin
            check("idle_line", 32'(TX_OUT), 32'd1);
            if (len_q.size() == 0) check("unexpected_len", 32'd1, 32'd0);
            else check("frame_len", 32'(run_len), 32'(len_q.pop_front()));
            idle_len = 0;
          end
          idle_len++;
        end
        prev_busy = Busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #12;
    check("reset_tx", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    #10 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_tx", 32'(TX_OUT), 32'd1);
    check("idle_busy", 32'(Busy), 32'd0);

    // Directed vectors with hand-computed parity bits.
    send(8'hA5, 1'b1, 1'b0, 1'b0);  // 4 ones, even -> 0
    send(8'h01, 1'b1, 1'b1, 1'b0);  // 1 one, odd -> 0
    send(8'h00, 1'b0, 1'b0, 1'b0);  // no parity bit
    send(8'h80, 1'b1, 1'b0, 1'b1);  // 1 one, even -> 1
    send(8'h07, 1'b1, 1'b0, 1'b1);  // 3 ones, even -> 1
    send(8'hFF, 1'b1, 1'b1, 1'b1);  // 8 ones, odd -> 1

    // Data_Valid held high: three back-to-back frames separated by one idle cycle.
    wait_idle();
    push_frame(8'h55, 1'b0, 1'b0, -1);
    push_frame(8'h55, 1'b0, 1'b0, 1);
    push_frame(8'h55, 1'b0, 1'b0, 1);
    $display("TX data=55 par_en=0 held x3");
    @(posedge CLK); #1;
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    edges = 2 * (10 + EXTRA + 1) + 1;
    repeat (edges) @(posedge CLK);
    #1 Data_Valid = 1'b0;

    // Request and input changes mid-frame must not disturb the 0x3C frame.
    wait_idle();
    push_frame(8'h3C, 1'b1, 1'b0, -1);
    $display("TX data=3C par_en=1 par_typ=0 with mid-frame 0xFF request");
    @(posedge CLK); #1;
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK); #1 Data_Valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1;
    @(posedge CLK); #1 P_DATA = 8'hC3;
    repeat (3) @(posedge CLK);
    #1 Data_Valid = 1'b0;

    // Asynchronous reset during data bit 4 of 0xA5 (bit 4 is 0).
    wait_idle();
    push_frame(8'hA5, 1'b1, 1'b0, -1);
    $display("TX data=A5 par_en=1 par_typ=0 aborted by reset");
    @(posedge CLK); #1;
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK); #1 Data_Valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    check("bit4_before_reset", 32'(TX_OUT), 32'd0);
    RST = 1'b0;
    #1;
    check("async_reset_tx", 32'(TX_OUT), 32'd1);
    check("async_reset_busy", 32'(Busy), 32'd0);
    bit_q.delete(); len_q.delete(); gap_q.delete();
    @(posedge CLK); #3 RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_reset_idle", 32'({TX_OUT, Busy}), 32'b10);
    end

    send(8'h5A, 1'b0, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge CLK);
    check("bit_q_drained", 32'(bit_q.size()), 32'd0);
    check("len_q_drained", 32'(len_q.size()), 32'd0);
    check("gap_q_drained", 32'(gap_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
